wb_trace_buffer: RTL and testbench
==================================

// Module: wb_trace_buffer
// PURPOSE
//  Parametrised write-back commit tracer for the pipelined MIPS core. Snoops WB-stage register writes
//  (WB_RD, WB_RD_DATA, WB_PC_4) and stores each commit as {pc, rd, data[, stamp]} in a circular buffer.
//  Software or the bench drains entries through a valid/ready port. Successor to fixed bench-side probing:
//  configurable depth, widths and overflow mode, with start/stop/clear control.
// PARAMETERS
//  DATA_W  32  width of written register data
//  PC_W    32  PC width; stored pc = wb_pc_4 - 4 (mod 2^PC_W)
//  RD_W    5   destination register index width
//  DEPTH   16  entries; power of two, >= 2
//  WRAP    0   0 = stop-on-full (freeze), 1 = overwrite oldest when full
//  TS_W    32  timestamp width (used only with TRACE_TIMESTAMP_EN)
// PORTS
//  CLK        in   1            clock, all state on rising edge
//  RESET      in   1            asynchronous, active-low reset
//  start      in   1            pulse: IDLE/FROZEN -> RUN
//  stop       in   1            pulse: RUN -> FROZEN
//  clear      in   1            pulse: empty buffer, clear flags, -> IDLE
//  wb_regwrite in  1            WB stage writes a register this cycle
//  wb_rd      in   RD_W         WB destination register
//  wb_data    in   DATA_W       WB write data
//  wb_pc_4    in   PC_W         WB PC+4
//  out_ready  in   1            consumer accepts head entry
//  out_valid  out  1            head entry available (= !empty)
//  out_pc     out  PC_W         head entry pc
//  out_rd     out  RD_W         head entry rd
//  out_data   out  DATA_W       head entry data
//  out_stamp  out  TS_W         head entry cycle stamp (macro only)
//  count      out  $clog2(DEPTH)+1  entries held
//  overflow   out  1            sticky: a commit was dropped or overwritten
//  running    out  1            state == RUN
// BEHAVIOUR
//  - Reset (RESET=0): state IDLE, rd/wr ptrs 0, count 0, overflow 0, out_valid 0, out_* 0, stamp ctr 0.
//  - FSM IDLE -start-> RUN; RUN -stop-> FROZEN; RUN -full & WRAP=0 & push-> FROZEN (that push still
//    stored only if it fills the last slot, else dropped & overflow=1); FROZEN -start-> RUN.
//    clear from any state -> IDLE, ptrs/count/overflow zeroed; clear beats start/stop same cycle;
//    stop beats start same cycle.
//  - Push = running & wb_regwrite & (wb_rd != 0). Stored next edge; visible on out_* 1 cycle after push.
//  - Pop = out_valid & out_ready; out_* are registered head, show next entry the cycle after pop.
//  - Simultaneous push & pop: count unchanged, both ptrs advance, legal when full and when count==1.
//  - Full, push, no pop: WRAP=0 -> drop, overflow=1, FROZEN; WRAP=1 -> overwrite oldest, rd ptr
//    advances, count stays DEPTH, overflow=1.
//  - Empty & pop request: ignored. Pointers wrap modulo DEPTH.
//  - Drain allowed in every state, including IDLE after stop-and-clear? no: clear empties immediately.
//  - Async reset mid-operation discards all entries; no partial entry survives.
// CONFIGURATION
//  `TRACE_TIMESTAMP_EN defined: free-running TS_W-bit cycle counter (starts at 0 after reset, wraps,
//   not reset by clear) captured with each entry; out_stamp valid. Undefined: no counter or stamp
//   storage; out_stamp tied to 0.
// STRUCTURE
//  - Shared package mips_trace_pkg: trace_state_t enum {IDLE, RUN, FROZEN}, trace_entry_t struct
//    parameters bound per instance, REG_ZERO constant.
//  - One sub-module: trace_ram (DEPTH x entry-width, 1W/1R, synchronous read). FSM, ptrs, count,
//    overflow and stamp in top.
// TESTING
//  1 Reset: RESET=0 mid-run with 5 entries -> count=0, out_valid=0, overflow=0, running=0.
//  2 start, commit rd=8 data=0x0000_00AA pc_4=0x0040_0004 -> next cycle out_valid=1, out_pc=0x0040_0000.
//  3 WRAP=0, DEPTH=16, 17 commits no pop -> count=16, overflow=1, state FROZEN, entry 17 absent.
//  4 WRAP=1, 20 commits data=1..20 no pop -> count=16, overflow=1, drained data 5..20 in order.
//  5 Full with out_ready=1 and push every cycle for 40 cycles -> count stays 16, no overflow, order kept.
//  6 Commit to rd=0, and commit while IDLE/FROZEN -> ignored, count unchanged; with TRACE_TIMESTAMP_EN
//    stamps of back-to-back commits differ by exactly 1.

Source files
------------

// File: rtl/mips_trace_pkg.sv
// Shared definitions for the write-back commit tracer.
//   trace_state_t : capture FSM states (IDLE, RUN, FROZEN)
//   REG_ZERO      : index of the hard-wired zero register; writes to it are never traced
//   ptr_width()   : address width of a DEPTH-entry circular buffer
// The entry layout (trace_entry_t) is declared inside wb_trace_buffer because its field widths
// are bound per instance.
package mips_trace_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } trace_state_t;

    localparam int unsigned REG_ZERO = 0;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Entry storage for the commit tracer: DEPTH x WIDTH, one write port, one synchronous read port.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset (clears the read register only)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address, sampled on the rising edge
//   rdata  : registered read data
// A same-edge write to the address being read is forwarded, so rdata always reflects the
// array contents after the edge.
module trace_ram #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back commit tracer. Snoops WB-stage register writes and stores each commit as
// {pc, rd, data[, stamp]} in a circular buffer drained through a valid/ready port.
// Optional feature: define TRACE_TIMESTAMP_EN to add a free-running cycle stamp to every entry.
// Ports:
//   CLK, RESET       : clock, asynchronous active-low reset
//   start/stop/clear : capture control pulses (clear > stop > start)
//   wb_regwrite, wb_rd, wb_data, wb_pc_4 : WB-stage commit snoop
//   out_ready        : consumer accepts the head entry
//   out_valid, out_pc, out_rd, out_data, out_stamp : registered head entry
//   count            : entries held
//   overflow         : sticky, a commit was dropped or overwritten
//   running          : capture FSM is in RUN
module wb_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WRAP   = 0,
    parameter int unsigned TS_W   = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   clear,
    input  logic                   wb_regwrite,
    input  logic [RD_W-1:0]        wb_rd,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic [PC_W-1:0]        wb_pc_4,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [PC_W-1:0]        out_pc,
    output logic [RD_W-1:0]        out_rd,
    output logic [DATA_W-1:0]      out_data,
    output logic [TS_W-1:0]        out_stamp,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   running
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

`ifdef TRACE_TIMESTAMP_EN
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   stamp;
    } trace_entry_t;
`else
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } trace_entry_t;
`endif

    localparam int unsigned ENTRY_W = $bits(trace_entry_t);

    trace_state_t     state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full, push, pop, we, rd_adv;
    trace_entry_t     wr_entry, rd_entry;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = (state_q == RUN) && wb_regwrite && (wb_rd != RD_W'(REG_ZERO));
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        we         = 1'b0;
        rd_adv     = 1'b0;
        if (clear) begin
            state_d    = IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (stop) begin
                if (state_q == RUN) begin
                    state_d = FROZEN;
                end
            end else if (start && (state_q != RUN)) begin
                state_d = RUN;
            end
            rd_adv = pop;
            if (push) begin
                if (full && !pop) begin
                    overflow_d = 1'b1;
                    if (WRAP != 0) begin
                        // Overwrite the oldest slot; the head moves past it.
                        we     = 1'b1;
                        rd_adv = 1'b1;
                    end else begin
                        state_d = FROZEN;
                    end
                end else begin
                    we = 1'b1;
                end
            end
            if (we) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_adv) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(we) - CNT_W'(rd_adv);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_entry.pc   = wb_pc_4 - PC_W'(4);
    assign wr_entry.rd   = wb_rd;
    assign wr_entry.data = wb_data;

`ifdef TRACE_TIMESTAMP_EN
    // Cycle counter; only reset clears it, clear does not.
    logic [TS_W-1:0] stamp_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stamp_q <= '0;
        end else begin
            stamp_q <= stamp_q + TS_W'(1);
        end
    end

    assign wr_entry.stamp = stamp_q;
    assign out_stamp      = rd_entry.stamp;
`else
    assign out_stamp = '0;
`endif

    // Reading at the next-state head address makes the RAM output register the head entry.
    trace_ram #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (CLK),
        .rst_n (RESET),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_d),
        .rdata (rd_entry)
    );

    assign out_pc   = rd_entry.pc;
    assign out_rd   = rd_entry.rd;
    assign out_data = rd_entry.data;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign running  = (state_q == RUN);

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: a stop-on-full instance and a wrapping instance share one
// stimulus stream; a queue-based model per instance is compared every cycle.
module tb_wb_trace_buffer;

    localparam int DEPTH    = 16;
    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_FROZEN = 2;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] stamp;
    } ent_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic        wb_regwrite = 1'b0, out_ready = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0, wb_pc_4 = '0;

    logic        nw_valid, nw_ovf, nw_run, w_valid, w_ovf, w_run;
    logic [31:0] nw_pc, nw_data, nw_stamp, w_pc, w_data, w_stamp;
    logic [4:0]  nw_rd, nw_count, w_rd, w_count;

    int checks = 0;
    int errors = 0;

    wb_trace_buffer #(.DEPTH(DEPTH), .WRAP(0)) u_nowrap (
        .CLK(CLK), .RESET(RESET), .start(start), .stop(stop), .clear(clear),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc_4(wb_pc_4),
        .out_ready(out_ready), .out_valid(nw_valid), .out_pc(nw_pc), .out_rd(nw_rd),
        .out_data(nw_data), .out_stamp(nw_stamp), .count(nw_count), .overflow(nw_ovf),
        .running(nw_run)
    );

    wb_trace_buffer #(.DEPTH(DEPTH), .WRAP(1)) u_wrap (
        .CLK(CLK), .RESET(RESET), .start(start), .stop(stop), .clear(clear),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc_4(wb_pc_4),
        .out_ready(out_ready), .out_valid(w_valid), .out_pc(w_pc), .out_rd(w_rd),
        .out_data(w_data), .out_stamp(w_stamp), .count(w_count), .overflow(w_ovf),
        .running(w_run)
    );

    initial forever #5 CLK = ~CLK;

    // ---------------- model ----------------
    ent_t        q0[$];
    ent_t        q1[$];
    int          mst[2] = '{S_IDLE, S_IDLE};
    bit          movf[2] = '{1'b0, 1'b0};
    logic [31:0] mstamp = '0;

    function automatic int mq_size(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ent_t mq_head(input int m);
        return (m == 0) ? q0[0] : q1[0];
    endfunction

    task automatic mq_push(input int m, input ent_t e);
        if (m == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mq_pop(input int m);
        if (m == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    task automatic mq_clear(input int m);
        if (m == 0) q0.delete();
        else q1.delete();
    endtask

    // m == 1 is the wrapping instance.
    task automatic model_step(input int m);
        bit   do_pop, do_push;
        int   nst;
        ent_t e;
        do_pop  = (mq_size(m) != 0) && out_ready;
        do_push = (mst[m] == S_RUN) && wb_regwrite && (wb_rd != 5'd0);
        if (clear) begin
            mq_clear(m);
            movf[m] = 1'b0;
            mst[m]  = S_IDLE;
        end else begin
            nst = mst[m];
            if (stop) begin
                if (mst[m] == S_RUN) nst = S_FROZEN;
            end else if (start && mst[m] != S_RUN) begin
                nst = S_RUN;
            end
            if (do_pop) mq_pop(m);
            if (do_push) begin
                e.pc    = wb_pc_4 - 32'd4;
                e.rd    = wb_rd;
                e.data  = wb_data;
                e.stamp = mstamp;
                if (mq_size(m) == DEPTH) begin
                    movf[m] = 1'b1;
                    if (m == 1) begin
                        mq_pop(m);
                        mq_push(m, e);
                    end else begin
                        nst = S_FROZEN;
                    end
                end else begin
                    mq_push(m, e);
                end
            end
            mst[m] = nst;
        end
    endtask

    initial forever begin
        @(posedge CLK or negedge RESET);
        if (!RESET) begin
            q0.delete();
            q1.delete();
            mst[0]  = S_IDLE;
            mst[1]  = S_IDLE;
            movf[0] = 1'b0;
            movf[1] = 1'b0;
            mstamp  = '0;
        end else begin
            model_step(0);
            model_step(1);
            mstamp = mstamp + 32'd1;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int m);
        logic        v, ov, run;
        logic [31:0] pc, data, st, exp_st;
        logic [4:0]  rd, cnt;
        ent_t        h;
        string       p;
        int          sz;
        if (m == 0) begin
            v = nw_valid; ov = nw_ovf; run = nw_run; pc = nw_pc; data = nw_data;
            st = nw_stamp; rd = nw_rd; cnt = nw_count; p = "nowrap";
        end else begin
            v = w_valid; ov = w_ovf; run = w_run; pc = w_pc; data = w_data;
            st = w_stamp; rd = w_rd; cnt = w_count; p = "wrap";
        end
        sz = mq_size(m);
        chk({p, ".out_valid"}, 64'(v), 64'(sz != 0));
        chk({p, ".count"}, 64'(cnt), 64'(sz));
        chk({p, ".overflow"}, 64'(ov), 64'(movf[m]));
        chk({p, ".running"}, 64'(run), 64'(mst[m] == S_RUN));
        if (sz != 0) begin
            h = mq_head(m);
`ifdef TRACE_TIMESTAMP_EN
            exp_st = h.stamp;
`else
            exp_st = 32'd0;
`endif
            chk({p, ".out_pc"}, 64'(pc), 64'(h.pc));
            chk({p, ".out_rd"}, 64'(rd), 64'(h.rd));
            chk({p, ".out_data"}, 64'(data), 64'(h.data));
            chk({p, ".out_stamp"}, 64'(st), 64'(exp_st));
        end
    endtask

    initial forever begin
        @(negedge CLK);
        cmp_dut(0);
        cmp_dut(1);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc4);
        wb_regwrite = 1'b1;
        wb_rd       = rd;
        wb_data     = data;
        wb_pc_4     = pc4;
        tick();
    endtask

    initial begin
        logic [31:0] s1, s2;
        #1 RESET = 1'b0;
        tick();
        tick();
        chk("reset.count", 64'(nw_count), 64'd0);
        chk("reset.out_valid", 64'(w_valid), 64'd0);
        chk("reset.out_pc", 64'(nw_pc), 64'd0);
        #2 RESET = 1'b1;
        tick();

        // First commit visible one cycle later with pc = pc_4 - 4.
        start = 1'b1; tick(); start = 1'b0;
        commit(5'd8, 32'h0000_00AA, 32'h0040_0004);
        wb_regwrite = 1'b0;
        chk("first.out_valid", 64'(nw_valid), 64'd1);
        chk("first.out_pc", 64'(nw_pc), 64'h0040_0000);
        chk("first.out_data", 64'(w_data), 64'h0000_00AA);
        for (int i = 1; i <= 4; i++) commit(5'(i + 8), 32'(i), 32'h0040_0004 + 32'(4 * i));
        wb_regwrite = 1'b0;
        chk("five.count", 64'(nw_count), 64'd5);

        // Asynchronous reset mid-run.
        #2 RESET = 1'b0;
        tick();
        chk("midreset.count", 64'(nw_count), 64'd0);
        chk("midreset.out_valid", 64'(nw_valid), 64'd0);
        chk("midreset.overflow", 64'(w_ovf), 64'd0);
        chk("midreset.running", 64'(w_run), 64'd0);
        #2 RESET = 1'b1;
        tick();

        // Ignored commits: IDLE, rd=0, FROZEN.
        commit(5'd3, 32'h33, 32'h104);
        wb_regwrite = 1'b0;
        chk("idle_commit.count", 64'(nw_count), 64'd0);
        start = 1'b1; tick(); start = 1'b0;
        commit(5'd0, 32'h44, 32'h108);
        wb_regwrite = 1'b0;
        chk("rd0_commit.count", 64'(w_count), 64'd0);
        commit(5'd1, 32'h11, 32'h10C);
        commit(5'd2, 32'h22, 32'h110);
        wb_regwrite = 1'b0;
        s1 = nw_stamp;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        s2 = nw_stamp;
`ifdef TRACE_TIMESTAMP_EN
        chk("stamp.delta", 64'(s2 - s1), 64'd1);
`endif
        chk("after_pop.out_data", 64'(nw_data), 64'h22);
        stop = 1'b1; tick(); stop = 1'b0;
        commit(5'd4, 32'h55, 32'h114);
        wb_regwrite = 1'b0;
        chk("frozen_commit.count", 64'(nw_count), 64'd1);
        chk("frozen.running", 64'(nw_run), 64'd0);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("stop_beats_start.running", 64'(nw_run), 64'd0);
        clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
        chk("clear_beats_start.running", 64'(w_run), 64'd0);
        chk("clear.count", 64'(w_count), 64'd0);

        // 20 commits without draining: freeze vs overwrite.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 20; i++) commit(5'((i % 31) + 1), 32'(i), 32'h1000 + 32'(4 * i));
        wb_regwrite = 1'b0;
        chk("full_nowrap.count", 64'(nw_count), 64'd16);
        chk("full_nowrap.overflow", 64'(nw_ovf), 64'd1);
        chk("full_nowrap.running", 64'(nw_run), 64'd0);
        chk("full_wrap.count", 64'(w_count), 64'd16);
        chk("full_wrap.overflow", 64'(w_ovf), 64'd1);
        chk("full_wrap.running", 64'(w_run), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_nowrap.data", 64'(nw_data), 64'(i + 1));
            chk("drain_wrap.data", 64'(w_data), 64'(i + 5));
            tick();
        end
        out_ready = 1'b0;
        chk("drained.count", 64'(w_count), 64'd0);
        clear = 1'b1; tick(); clear = 1'b0;

        // Full buffer with simultaneous push and pop every cycle.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 16; i++) commit(5'(i + 1), 32'(200 + i), 32'h2000 + 32'(4 * i));
        wb_regwrite = 1'b0;
        chk("fill.running", 64'(nw_run), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) commit(5'((i % 31) + 1), 32'(300 + i), 32'h3000 + 32'(4 * i));
        wb_regwrite = 1'b0;
        chk("stream_nowrap.count", 64'(nw_count), 64'd16);
        chk("stream_nowrap.overflow", 64'(nw_ovf), 64'd0);
        chk("stream_wrap.overflow", 64'(w_ovf), 64'd0);
        chk("stream.head_data", 64'(nw_data), 64'd324);
        repeat (16) tick();
        out_ready = 1'b0;
        chk("stream_drained.count", 64'(nw_count), 64'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
